int_ctrl: RTL
=============

# int_ctrl

Interrupt/exception controller driving the fetch stage's redirect inputs (`int_flush`, `int_pc`). It watches hardware interrupt lines, `syscall`, and `eret` at the execute stage, and holds a minimal CP0 register set (Status, Cause, EPC). It emits a one-cycle flush toward the next-PC logic: either to the exception vector on entry or to EPC on return. It sits beside the execute stage and its outputs go straight into next-PC selection.

## Interface
- `NUM_IRQ`, 6: number of hardware interrupt lines.
- `EXC_VECTOR`, 32'h0000_0180: handler entry address.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `irq` in NUM_IRQ: level-sensitive interrupt requests.
- `ex_valid` in 1: execute stage holds a valid instruction that may be interrupted (safe point).
- `ex_pc` in 32: PC of that instruction.
- `ex_syscall` in 1: the execute-stage instruction is `syscall`.
- `ex_eret` in 1: the execute-stage instruction is `eret`.
- `cp0_we` in 1: `mtc0` write strobe.
- `cp0_addr` in 5: CP0 register number (12 = Status, 13 = Cause, 14 = EPC).
- `cp0_wdata` in 32: `mtc0` data.
- `cp0_rdata` out 32: `mfc0` data, combinational from `cp0_addr`; 0 for unmapped addresses.
- `int_flush` out 1: redirect fetch; registered and one cycle wide.
- `int_pc` out 32: redirect target; valid while `int_flush` = 1, otherwise 0.
- `in_handler` out 1: Status.EXL.

## Operation
- Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM. Other bits read 0.
  - `mtc0` writes only IE and IM; EXL is writable only by the FSM.
- Cause: bits[6:2] ExcCode (0 = interrupt, 8 = syscall), bits[8+NUM_IRQ-1:8] IP.
  - IP mirrors the (synchronised) `irq` every cycle; not writable.
- EPC: 32-bit, writable by `mtc0`.
- `pending` = |(IP & IM) & IE & ~EXL.
- FSM states:
  - IDLE
    - If `ex_valid & pending`: EPC <= `ex_pc`, ExcCode <= 0, EXL <= 1, go to FLUSH_EXC.
    - Else if `ex_valid & ex_syscall & ~EXL`: EPC <= `ex_pc` + 4, ExcCode <= 8, EXL <= 1, go to FLUSH_EXC.
    - Else if `ex_valid & ex_eret`: go to FLUSH_RET.
  - FLUSH_EXC: `int_flush` = 1, `int_pc` = EXC_VECTOR; go to HANDLER. All `ex_*` inputs ignored.
  - HANDLER: interrupts and syscall ignored (EXL = 1). `ex_valid & ex_eret` goes to FLUSH_RET.
  - FLUSH_RET: `int_flush` = 1, `int_pc` = EPC, EXL <= 0; go to IDLE. `ex_*` inputs ignored.
- Priority in IDLE: interrupt > syscall > eret.
  - An interrupt that coincides with a syscall squashes the syscall; EPC = `ex_pc`, so the syscall re-executes.
- `eret` with EXL = 0 is still honoured (flush to EPC).
- A `mtc0` to EPC in the same cycle as exception capture loses; the FSM capture wins.
  - A `mtc0` to EPC in the FLUSH_RET cycle is applied, but the `int_pc` already driven is unaffected.
- `ex_pc` + 4 wraps modulo 2^32.

## Timing
- Reset values: `int_flush` 0, `int_pc` 0, `in_handler` 0, Status 0, Cause 0, EPC 0, state IDLE.
  - `cp0_rdata` follows the register values.
- Reset asserted mid-flush drops `int_flush` immediately (asynchronous reset).
- Latency: qualifying edge N → `int_flush` high during cycle N+1 only.
  - The `int_flush` pulse is exactly one cycle; two pulses are always separated by at least one cycle.
- `irq` → IP visible: 1 cycle (registered).
- CP0 writes take effect at the next edge.
  - A Status write clearing IE in cycle N blocks an interrupt evaluated in cycle N+1, but not one evaluated in cycle N.

## Configuration
- `INT_CTRL_IRQ_SYNC_EN`:
  - Defined: `irq` passes through a 2-flop synchroniser before IP, so `irq` → IP latency is 3 cycles.
  - Undefined: single register stage, 1 cycle.
  - Everything else is identical.

## Test plan
- Reset, then drive all inputs idle → all outputs 0; `cp0_rdata` reads 0 for addresses 12, 13, 14.
- Status ← 32'h0000_0101; `irq[0]` = 1; `ex_valid` = 1, `ex_pc` = 32'h0000_0040 → one-cycle `int_flush` with `int_pc` = 32'h0000_0180; then EPC = 32'h40, ExcCode = 0, `in_handler` = 1.
- Syscall at `ex_pc` = 32'hFFFF_FFFC with IE = 0 → flush to 32'h180; EPC = 32'h0000_0000 (wrap), ExcCode = 8.
- In HANDLER: raise `irq` and `syscall` → no flush. Then `eret` → `int_flush` with `int_pc` = EPC; `in_handler` = 0 in the next cycle.
- Interrupt and syscall in the same cycle at `ex_pc` = 32'h100 → EPC = 32'h100, ExcCode = 0. Also, `mtc0` to EPC in that same cycle does not overwrite the capture.
- Pending interrupt with `ex_valid` = 0 for 5 cycles → no flush. `ex_valid` = 1 → flush in the following cycle. Assert `rst` during the flush cycle → `int_flush` falls without waiting for a clock edge.

Source files
------------

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: execute-stage exception inputs, CP0 mtc0/mfc0 port and the
// fetch redirect outputs of the interrupt/exception controller.
interface int_ctrl_if #(
  parameter int NUM_IRQ = 6
);
  logic [NUM_IRQ-1:0] irq;
  logic               ex_valid;
  logic [31:0]        ex_pc;
  logic               ex_syscall;
  logic               ex_eret;
  logic               cp0_we;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_wdata;
  logic [31:0]        cp0_rdata;
  logic               int_flush;
  logic [31:0]        int_pc;
  logic               in_handler;

  modport master (
    output irq, ex_valid, ex_pc, ex_syscall, ex_eret, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, int_flush, int_pc, in_handler
  );

  modport slave (
    input  irq, ex_valid, ex_pc, ex_syscall, ex_eret, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, int_flush, int_pc, in_handler
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt/syscall/eret controller with CP0 Status/Cause/EPC and a one-cycle
// fetch redirect. Define INT_CTRL_IRQ_SYNC_EN to add a 2-flop irq synchroniser ahead of Cause.IP.
module int_ctrl #(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic       clk,
  input  logic       rst,
  int_ctrl_if.slave  bus
);

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] EXC_INT    = 5'd0;
  localparam logic [4:0] EXC_SYS    = 5'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH_EXC,
    S_HANDLER,
    S_FLUSH_RET
  } state_e;

  state_e              state_q, state_d;
  logic                ie_q, ie_d;
  logic                exl_q, exl_d;
  logic [NUM_IRQ-1:0]  im_q, im_d;
  logic [NUM_IRQ-1:0]  ip_q, ip_d;
  logic [4:0]          exc_code_q, exc_code_d;
  logic [31:0]         epc_q, epc_d;
  logic                flush_q, flush_d;
  logic [31:0]         int_pc_q, int_pc_d;

  logic [NUM_IRQ-1:0]  irq_s;
  logic                pending;
  logic                capture;

`ifdef INT_CTRL_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0]  sync1_q, sync1_d;
  logic [NUM_IRQ-1:0]  sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.irq;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq;
`endif

  assign ip_d    = irq_s;
  assign pending = (|(ip_q & im_q)) & ie_q & ~exl_q;

  // Exception entry/return sequencing; EPC capture here takes priority over mtc0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_d    = state_q;
    exl_d      = exl_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    flush_d    = 1'b0;
    int_pc_d   = '0;
    capture    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ex_valid && pending) begin
          epc_d      = bus.ex_pc;
          exc_code_d = EXC_INT;
          exl_d      = 1'b1;
          flush_d    = 1'b1;
          int_pc_d   = EXC_VECTOR;
          capture    = 1'b1;
          state_d    = S_FLUSH_EXC;
        end else if (bus.ex_valid && bus.ex_syscall && !exl_q) begin
          epc_d      = bus.ex_pc + 32'd4;
          exc_code_d = EXC_SYS;
          exl_d      = 1'b1;
          flush_d    = 1'b1;
          int_pc_d   = EXC_VECTOR;
          capture    = 1'b1;
          state_d    = S_FLUSH_EXC;
        end else if (bus.ex_valid && bus.ex_eret) begin
          flush_d    = 1'b1;
          int_pc_d   = epc_q;
          state_d    = S_FLUSH_RET;
        end
      end
      S_FLUSH_EXC: begin
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (bus.ex_valid && bus.ex_eret) begin
          flush_d  = 1'b1;
          int_pc_d = epc_q;
          state_d  = S_FLUSH_RET;
        end
      end
      S_FLUSH_RET: begin
        exl_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.cp0_we && (bus.cp0_addr == CP0_EPC) && !capture) begin
      epc_d = bus.cp0_wdata;
    end
  end

  // mtc0 reaches only IE and IM in Status; EXL belongs to the sequencer above.
  always_comb begin
    ie_d = ie_q;
    im_d = im_q;
    if (bus.cp0_we && (bus.cp0_addr == CP0_STATUS)) begin
      ie_d = bus.cp0_wdata[0];
      im_d = bus.cp0_wdata[8 +: NUM_IRQ];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      flush_q    <= 1'b0;
      int_pc_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      flush_q    <= flush_d;
      int_pc_q   <= int_pc_d;
    end
  end

  always_comb begin
    bus.cp0_rdata = '0;
    unique case (bus.cp0_addr)
      CP0_STATUS: begin
        bus.cp0_rdata[0]            = ie_q;
        bus.cp0_rdata[1]            = exl_q;
        bus.cp0_rdata[8 +: NUM_IRQ] = im_q;
      end
      CP0_CAUSE: begin
        bus.cp0_rdata[6:2]          = exc_code_q;
        bus.cp0_rdata[8 +: NUM_IRQ] = ip_q;
      end
      CP0_EPC: begin
        bus.cp0_rdata = epc_q;
      end
      default: begin
        bus.cp0_rdata = '0;
      end
    endcase
  end

  assign bus.int_flush  = flush_q;
  assign bus.int_pc     = int_pc_q;
  assign bus.in_handler = exl_q;

endmodule
